// File: rtl/disp_scan4.sv
// ---------------------------------------------------------------------------
// disp_scan4 - scan controller for a 4-digit common-anode 7-segment display.
//
// Steps a digit index through 0..3, holding each index for DIV clock cycles.
// For the current digit it drives an active-low segment pattern and an
// active-low decimal point. The first BLANK cycles of every digit slot are
// forced dark to stop ghosting between digits. Leading zeros can be hidden.
// A newly loaded display value only takes effect at a frame boundary, so one
// frame never shows a mix of the old and new values.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         scan enable; 0 freezes the scan position and the outputs
//   load       one-cycle strobe; captures value/dp_in into the shadow copy
//   value      four hex digits; digit i = value[4i+3:4i]
//   dp_in      decimal point request; bit i belongs to digit i
//   lz_blank   1 = hide leading zeros on digits 3..1
//   sel        current digit index; drives the downstream 2-to-4 decoder
//   seg_n      active-low segments {g,f,e,d,c,b,a}
//   dp_n       active-low decimal point
//   blank      1 while the segments are forced off
//   frame_done one-cycle pulse on the first cycle of each new frame
// ---------------------------------------------------------------------------
module disp_scan4 #(
  parameter int DIV   = 100000,
  parameter int BLANK = 4,
  parameter int CW    = $clog2(DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [1:0]  sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   shd_val_q, shd_val_d;
  logic [3:0]    shd_dp_q, shd_dp_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          blank_q, blank_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_wrap;
  logic          frame_wrap;
  logic [3:0]    digit;
  logic [3:0]    digit_zero;
  logic [3:0]    upper_zero;

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // upper_zero[i]: the next-state active digits i..3 are all zero.
  // Looked at against act_val_d so a value swapped in at the frame edge is
  // already reflected in the first slot of the new frame.
  for (genvar gi = 0; gi < 4; gi++) begin : g_zero
    assign digit_zero[gi] = (act_val_d[gi*4 +: 4] == 4'h0);
    assign upper_zero[gi] = &digit_zero[3:gi];
  end

  assign digit = act_val_d[{sel_d, 2'b00} +: 4];

  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    shd_val_d    = load ? value : shd_val_q;
    shd_dp_d     = load ? dp_in : shd_dp_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    seg_n_d      = seg_n_q;
    dp_n_d       = dp_n_q;
    blank_d      = blank_q;
    frame_done_d = 1'b0;

    slot_wrap  = (cnt_q == CNT_MAX);
    frame_wrap = en && slot_wrap && (sel_q == 2'd3);

    if (en) begin
      if (slot_wrap) begin
        cnt_d = '0;
        sel_d = sel_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // A load landing on the frame edge bypasses the shadow so it is not
    // delayed by a whole frame.
    if (frame_wrap) begin
      act_val_d    = load ? value : shd_val_q;
      act_dp_d     = load ? dp_in : shd_dp_q;
      frame_done_d = 1'b1;
    end

    // Outputs are built from the next (sel, cnt) so the registered values
    // line up with sel in the same cycle.
    if (en) begin
      if (cnt_d < BLANK_C) begin
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        blank_d = 1'b1;
      end else begin
        blank_d = 1'b0;
        dp_n_d  = ~act_dp_d[sel_d];
        if (lz_blank && (sel_d != 2'd0) && upper_zero[sel_d]) begin
          seg_n_d = 7'h7F;
        end else begin
          seg_n_d = hex_to_seg(digit);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      shd_val_q    <= 16'h0000;
      shd_dp_q     <= 4'h0;
      act_val_q    <= 16'h0000;
      act_dp_q     <= 4'h0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan4.sv
// ---------------------------------------------------------------------------
// tb_disp_scan4 - self-checking bench for disp_scan4 (DIV=4, BLANK=1).
// The reference tracks the scan as a single position p in 0..4*DIV-1 and
// derives digit/slot offset arithmetically; expected segments come from a
// lookup table of the required glyph codes.
// ---------------------------------------------------------------------------
module tb_disp_scan4;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_blank = 1'b0;
  logic [1:0]  sel;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        blank;
  logic        frame_done;

  disp_scan4 #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .sel(sel), .seg_n(seg_n),
    .dp_n(dp_n), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state
  int          p = 0;
  logic [15:0] m_shd = 16'h0, m_act = 16'h0;
  logic [3:0]  m_shd_dp = 4'h0, m_act_dp = 4'h0;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1, exp_blank = 1'b1, exp_fd = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic ld,
                      input logic [15:0] v, input logic [3:0] d,
                      input logic lz);
    int s, c, dig;
    rst = r; en = e; load = ld; value = v; dp_in = d; lz_blank = lz;
    if (r) begin
      p = 0; m_shd = 0; m_act = 0; m_shd_dp = 0; m_act_dp = 0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_blank = 1'b1; exp_fd = 1'b0;
    end else begin
      if (e) begin
        p = (p + 1) % (4 * DIV);
        if (p == 0) begin
          m_act    = ld ? v : m_shd;
          m_act_dp = ld ? d : m_shd_dp;
        end
      end
      if (ld) begin
        m_shd = v; m_shd_dp = d;
      end
      if (e) begin
        s = p / DIV;
        c = p % DIV;
        dig = int'((m_act >> (4 * s)) & 16'hF);
        exp_fd = (p == 0);
        if (c < BLANK) begin
          exp_seg = 7'h7F; exp_dp = 1'b1; exp_blank = 1'b1;
        end else begin
          exp_blank = 1'b0;
          exp_dp = ~m_act_dp[s];
          if (lz && s > 0 && (m_act >> (4 * s)) == 16'h0) exp_seg = 7'h7F;
          else exp_seg = seg_tab[dig];
        end
      end else begin
        exp_fd = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
    check_eq("sel",        {14'h0, sel},        16'(p / DIV));
    check_eq("seg_n",      {9'h0, seg_n},       {9'h0, exp_seg});
    check_eq("dp_n",       {15'h0, dp_n},       {15'h0, exp_dp});
    check_eq("blank",      {15'h0, blank},      {15'h0, exp_blank});
    check_eq("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
  endtask

  task automatic run(input int n, input logic lz, input logic [3:0] d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0, d, lz);
  endtask

  initial begin
    logic [15:0] v;
    // Reset and first directed frame with 16'h1A08
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h1A08, 4'b0000, 1'b0);
    run(40, 1'b0, 4'h0);
    // Leading-zero suppression, then all-zero value
    step(1'b0, 1'b1, 1'b1, 16'h0048, 4'b0000, 1'b1);
    run(40, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 4'b0000, 1'b1);
    run(40, 1'b1, 4'h0);
    // Decimal point on digit 2
    step(1'b0, 1'b1, 1'b1, 16'h1A08, 4'b0100, 1'b0);
    run(40, 1'b0, 4'h0);
    // Mid-frame load at sel=2
    while (p != 2 * DIV + 1) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'hFFFF, 4'b0000, 1'b0);
    run(24, 1'b0, 4'h0);
    // Freeze at sel=1, cnt=2 for 7 cycles
    while (p != DIV + 2) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    run(24, 1'b0, 4'h0);
    // Reset while sel=2
    while (p != 2 * DIV + 2) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    run(20, 1'b0, 4'h0);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) == 0, v, 4'($urandom),
           $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
